// File: rtl/figure_pkg.sv
// Shared types and constants for player figure motion and drawing.
// Pure declarations, no logic and no latency.
// No flow control: consumers simply import these definitions.
package figure_pkg;

  // Vertical motion state; encoding is visible on the state output.
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    JUMP   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  // Drawn sprite size (26 px source art at 2x scale), shared with the draw stage.
  localparam int SPRITE_W_DEFAULT = 52;
  localparam int SPRITE_H_DEFAULT = 64;

endpackage

// File: rtl/figure_ctl_if.sv
// Key inputs, frame timing and sprite position bundle for one player figure.
// Signals only; the controller registers outputs so they hold all frame.
// No handshake: keys are levels, position is a registered snapshot.
interface figure_ctl_if;
  import figure_pkg::*;

  logic          vblnk;
  logic          move_left;
  logic          move_right;
  logic          jump;
  logic [11:0]   pos_x;
  logic [11:0]   pos_y;
  motion_state_t state;
  logic          on_ground;

  // Timing chain / keyboard side: drives levels, observes position.
  modport master (
    output vblnk, move_left, move_right, jump,
    input  pos_x, pos_y, state, on_ground
  );

  // Controller side.
  modport slave (
    input  vblnk, move_left, move_right, jump,
    output pos_x, pos_y, state, on_ground
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vertical blanking: one tick per frame.
// Tick is combinational in the cycle vblnk is first seen high.
// No backpressure; a long blanking interval still yields a single tick.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic i_vblnk,
  output logic o_tick
);

  logic r_vblnk_q;

  // Delayed copy of vblnk for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vblnk_q <= 1'b0;
    else     r_vblnk_q <= i_vblnk;
  end

  assign o_tick = i_vblnk & ~r_vblnk_q;

endmodule

// File: rtl/figure_ctl.sv
// Per-frame motion controller: walking plus jump/fall for one figure.
// Position/state update on the edge ending the vblnk tick cycle (1 cycle).
// No backpressure; key levels are sampled only at the frame tick.
module figure_ctl
  import figure_pkg::*;
#(
  parameter int X_INIT   = 100,
  parameter int FLOOR_Y  = 500,
  parameter int Y_MIN    = 0,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 800,
  parameter int SPRITE_W = SPRITE_W_DEFAULT,
  parameter int STEP_X   = 4,
  parameter int JUMP_V0  = 16,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 16
) (
  input  logic         clk,
  input  logic         rst,
  figure_ctl_if.slave  bus
);

  // 13-bit signed so left steps can go below zero before clamping.
  localparam logic signed [12:0] LP_X_MIN = 13'(X_MIN);
  localparam logic signed [12:0] LP_X_HI  = 13'(X_MAX - SPRITE_W);
  localparam logic signed [12:0] LP_STEP  = 13'(STEP_X);
  localparam logic signed [12:0] LP_Y_MIN = 13'(Y_MIN);
  localparam logic signed [12:0] LP_FLOOR = 13'(FLOOR_Y);

  logic          w_tick;
  motion_state_t r_state;
  motion_state_t w_state_nx;
  logic [11:0]   r_pos_x;
  logic [11:0]   r_pos_y;
  logic [7:0]    r_vel;
  logic          r_jump_prev;
  logic [11:0]   w_x_nx;
  logic [11:0]   w_y_nx;
  logic [7:0]    w_vel_nx;
  logic          w_jump_req;

  logic signed [12:0] w_x_ext;
  logic signed [12:0] w_x_tmp;
  logic signed [12:0] w_y_ext;
  logic signed [12:0] w_y_up;
  logic signed [12:0] w_y_dn;
  logic [8:0]         w_vinc;
  logic [8:0]         w_vfall;

  frame_tick_gen u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_vblnk (bus.vblnk),
    .o_tick  (w_tick)
  );

  // Fresh press only: key must have been up at the previous tick.
  assign w_jump_req = bus.jump & ~r_jump_prev;

  assign w_x_ext = $signed({1'b0, r_pos_x});
  assign w_y_ext = $signed({1'b0, r_pos_y});
  assign w_y_up  = w_y_ext - $signed({5'b0, r_vel});
  assign w_vinc  = {1'b0, r_vel} + 9'(GRAVITY);
  assign w_vfall = (w_vinc > 9'(V_MAX)) ? 9'(V_MAX) : w_vinc;
  assign w_y_dn  = w_y_ext + $signed({4'b0, w_vfall});

  // Horizontal walk with screen-edge clamps; conflicting keys hold.
  always_comb begin
    w_x_tmp = w_x_ext;
    if (bus.move_left && !bus.move_right) begin
      w_x_tmp = w_x_ext - LP_STEP;
      if (w_x_tmp < LP_X_MIN) w_x_tmp = LP_X_MIN;
    end else if (bus.move_right && !bus.move_left) begin
      w_x_tmp = w_x_ext + LP_STEP;
      if (w_x_tmp > LP_X_HI) w_x_tmp = LP_X_HI;
    end
    w_x_nx = w_x_tmp[11:0];
  end

  // Jump/fall next-state, vertical position and speed.
  always_comb begin
    w_state_nx = r_state;
    w_y_nx     = r_pos_y;
    w_vel_nx   = r_vel;
    case (r_state)
      GROUND: begin
        w_y_nx   = 12'(FLOOR_Y);
        w_vel_nx = 8'd0;
        if (w_jump_req) begin
          w_state_nx = JUMP;
          w_vel_nx   = 8'(JUMP_V0);
        end
      end
      JUMP: begin
        // Ceiling clamps position only; the rise runs its full course.
        w_y_nx = (w_y_up < LP_Y_MIN) ? 12'(Y_MIN) : w_y_up[11:0];
        if (r_vel <= 8'(GRAVITY)) begin
          w_state_nx = FALL;
          w_vel_nx   = 8'd0;
        end else begin
          w_vel_nx = r_vel - 8'(GRAVITY);
        end
      end
      FALL: begin
        if (w_y_dn >= LP_FLOOR) begin
          w_y_nx     = 12'(FLOOR_Y);
          w_state_nx = GROUND;
          w_vel_nx   = 8'd0;
        end else begin
          w_y_nx   = w_y_dn[11:0];
          w_vel_nx = w_vfall[7:0];
        end
      end
      default: begin
        w_state_nx = GROUND;
        w_y_nx     = 12'(FLOOR_Y);
        w_vel_nx   = 8'd0;
      end
    endcase
  end

  // All motion registers advance only on the frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= GROUND;
      r_pos_x     <= 12'(X_INIT);
      r_pos_y     <= 12'(FLOOR_Y);
      r_vel       <= 8'd0;
      r_jump_prev <= 1'b0;
    end else if (w_tick) begin
      r_state     <= w_state_nx;
      r_pos_x     <= w_x_nx;
      r_pos_y     <= w_y_nx;
      r_vel       <= w_vel_nx;
      r_jump_prev <= bus.jump;
    end
  end

  assign bus.pos_x     = r_pos_x;
  assign bus.pos_y     = r_pos_y;
  assign bus.state     = r_state;
  assign bus.on_ground = (r_state == GROUND);

endmodule

// File: tb/tb_figure_ctl.sv
// Directed bench for figure_ctl: vector table plus multi-cycle sequences.
module tb_figure_ctl;
  import figure_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  figure_ctl_if bus ();
  figure_ctl_if bus2 ();

  figure_ctl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance starting near the left edge, same keys and timing.
  figure_ctl #(.X_INIT(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.vblnk      = bus.vblnk;
  assign bus2.move_left  = bus.move_left;
  assign bus2.move_right = bus.move_right;
  assign bus2.jump       = bus.jump;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic l;
    logic r;
    logic j;
    int   x;
    int   y;
    int   st;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One frame: vblnk rises for a cycle, then a short active period.
  task automatic frame();
    bus.vblnk = 1'b1;
    @(posedge clk); #1;
    bus.vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic keys(input logic l, input logic r, input logic j);
    bus.move_left  = l;
    bus.move_right = r;
    bus.jump       = j;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keys(1'b0, 1'b0, 1'b0);
    bus.vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // left, right, jump -> x, y, state after that tick
    tbl[0] = '{1'b0, 1'b1, 1'b0, 104, 500, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 108, 500, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 108, 500, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 108, 500, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 104, 500, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 108, 500, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 108, 484, 1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 104, 469, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 104, 455, 1};

    rst = 1'b1;
    keys(1'b0, 1'b0, 1'b0);
    bus.vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", int'(bus.pos_x), 100);
    check("rst_y", int'(bus.pos_y), 500);
    check("rst_state", int'(bus.state), 0);
    check("rst_on_ground", int'(bus.on_ground), 1);
    check("rst_x2", int'(bus2.pos_x), 2);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      keys(tbl[i].l, tbl[i].r, tbl[i].j);
      frame();
      check($sformatf("vec%0d_x", i), int'(bus.pos_x), tbl[i].x);
      check($sformatf("vec%0d_y", i), int'(bus.pos_y), tbl[i].y);
      check($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].st);
      check($sformatf("vec%0d_on_ground", i), int'(bus.on_ground), (tbl[i].st == 0) ? 1 : 0);
    end

    // Async reset mid-frame while airborne: no clock edge needed.
    keys(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_x", int'(bus.pos_x), 100);
    check("async_rst_y", int'(bus.pos_y), 500);
    check("async_rst_state", int'(bus.state), 0);
    check("async_rst_on_ground", int'(bus.on_ground), 1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Left clamp: 2 -> 0 on the second instance, main instance 100 -> 96.
    keys(1'b1, 1'b0, 1'b0);
    frame();
    check("left_clamp_x2", int'(bus2.pos_x), 0);
    check("left_step_x", int'(bus.pos_x), 96);
    frame();
    check("left_clamp_hold_x2", int'(bus2.pos_x), 0);

    // Walk right 10 ticks from reset.
    do_reset();
    keys(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) frame();
    check("walk_right_x", int'(bus.pos_x), 140);

    // Continue to 744, then hit the right clamp at 748.
    for (int i = 0; i < 151; i++) frame();
    check("pre_clamp_x", int'(bus.pos_x), 744);
    frame();
    check("right_clamp_x", int'(bus.pos_x), 748);
    for (int i = 0; i < 3; i++) begin
      frame();
      check($sformatf("right_clamp_hold%0d", i), int'(bus.pos_x), 748);
    end
    keys(1'b1, 1'b1, 1'b0);
    frame();
    check("both_keys_hold_x", int'(bus.pos_x), 748);

    // Full jump with the key held from tick 1.
    do_reset();
    keys(1'b0, 1'b0, 1'b1);
    frame();
    check("jump_t1_state", int'(bus.state), 1);
    check("jump_t1_y", int'(bus.pos_y), 500);
    check("jump_t1_on_ground", int'(bus.on_ground), 0);
    frame();
    check("jump_t2_y", int'(bus.pos_y), 484);
    for (int i = 3; i <= 16; i++) frame();
    check("jump_t16_y", int'(bus.pos_y), 365);
    check("jump_t16_state", int'(bus.state), 1);
    frame();
    check("apex_y", int'(bus.pos_y), 364);
    check("apex_state", int'(bus.state), 2);
    frame();
    check("fall_t18_y", int'(bus.pos_y), 365);
    for (int i = 19; i <= 32; i++) frame();
    check("fall_t32_y", int'(bus.pos_y), 484);
    check("fall_t32_state", int'(bus.state), 2);
    frame();
    check("land_y", int'(bus.pos_y), 500);
    check("land_state", int'(bus.state), 0);
    check("land_on_ground", int'(bus.on_ground), 1);
    frame();
    frame();
    check("no_rejump_state", int'(bus.state), 0);
    keys(1'b0, 1'b0, 1'b0);
    frame();
    check("released_state", int'(bus.state), 0);
    keys(1'b0, 1'b0, 1'b1);
    frame();
    check("rejump_state", int'(bus.state), 1);
    frame();
    check("rejump_y", int'(bus.pos_y), 484);

    // vblnk held high for 1000 cycles: exactly one update.
    do_reset();
    keys(1'b0, 1'b1, 1'b0);
    bus.vblnk = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("long_vblnk_x", int'(bus.pos_x), 104);
    bus.vblnk = 1'b0;
    @(posedge clk); #1;
    frame();
    check("next_frame_x", int'(bus.pos_x), 108);

    // Reset at the apex: immediate return, no landing sequence.
    do_reset();
    keys(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 17; i++) frame();
    check("apex2_y", int'(bus.pos_y), 364);
    rst = 1'b1;
    #1;
    check("apex_rst_y", int'(bus.pos_y), 500);
    check("apex_rst_state", int'(bus.state), 0);
    check("apex_rst_on_ground", int'(bus.on_ground), 1);
    @(posedge clk); #1 rst = 1'b0;
    keys(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
